// File: rtl/wvga_sync_pkg.sv
// wvga_sync_pkg: default WVGA 800x480 timing, coordinate widths and the
// lock-qualifier state encoding shared by the sync generator files.
package wvga_sync_pkg;

    // Horizontal timing in pixel clocks.
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BACK   = 112;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    // Vertical timing in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 5;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 12;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Consecutive synchronized lock-high clocks before timing starts.
    localparam int DEF_LOCK_SETTLE = 1024;

    // Coordinate widths; the counters share them.
    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Lock qualifier states.
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

endpackage

// File: rtl/wvga_sync_gen_lock_qualifier.sv
// lock_qualifier: 2-FF synchronizer for the PLL lock pin plus the settle
// counter / state machine. lock_ok is high only in RUN while the synchronized
// lock is still high, so timing stops the same clock lock_s falls.
module lock_qualifier
    import wvga_sync_pkg::*;
#(
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    output logic lock_ok,
    output logic lock_drop
);

    localparam int                 CNT_W     = $clog2(LOCK_SETTLE + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(LOCK_SETTLE - 1);

    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q,    lock_s_d;
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    // Next-state logic: synchronizer shift, then WAIT_LOCK -> SETTLE -> RUN.
    // The clock that moves WAIT_LOCK to SETTLE already saw lock_s high, so it
    // is counted as the first settle clock.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lock_ok   = (state_q == ST_RUN) && lock_s_q;
    assign lock_drop = (state_q == ST_RUN) && !lock_s_q;

endmodule

// File: rtl/wvga_sync_gen.sv
// wvga_sync_gen: WVGA video timing generator. Qualifies PLL lock, then runs
// the h/v counters and produces registered, mutually aligned sync/DE/position
// outputs. Optional sticky lock-loss flag under `SYNCGEN_LOCKLOSS_EN.
module wvga_sync_gen
    import wvga_sync_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pll_lock,
    input  logic           lock_lost_clr,
    output logic           running,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           de,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           line_start,
    output logic           frame_start,
    output logic           lock_lost
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_W-1:0] X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FRONT);
    localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FRONT);
    localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic lock_ok;
    logic lock_drop;

    logic [X_W-1:0] hcnt_q, hcnt_d;
    logic [Y_W-1:0] vcnt_q, vcnt_d;

    logic           running_q,     running_d;
    logic           hsync_n_q,     hsync_n_d;
    logic           vsync_n_q,     vsync_n_d;
    logic           de_q,          de_d;
    logic [X_W-1:0] pos_x_q,       pos_x_d;
    logic [Y_W-1:0] pos_y_q,       pos_y_d;
    logic           line_start_q,  line_start_d;
    logic           frame_start_q, frame_start_d;

    lock_qualifier #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_qualifier (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .lock_ok   (lock_ok),
        .lock_drop (lock_drop)
    );

    // Raster counters: held at the origin until lock qualifies, so every
    // start is a fresh frame; losing lock overrides any pending wrap.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!lock_ok) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + Y_ONE;
        end else begin
            hcnt_d = hcnt_q + X_ONE;
        end
    end

    // Output decode from the current counters; idle values when not locked.
    // Positions only follow the counters inside the active area.
    always_comb begin
        running_d     = lock_ok;
        de_d          = lock_ok && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hsync_n_d     = !(lock_ok && (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        vsync_n_d     = !(lock_ok && (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
        line_start_d  = lock_ok && (hcnt_q == '0);
        frame_start_d = lock_ok && (hcnt_q == '0) && (vcnt_q == '0);
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        if (!lock_ok) begin
            pos_x_d = '0;
            pos_y_d = '0;
        end else if (de_d) begin
            pos_x_d = hcnt_q;
            pos_y_d = vcnt_q;
        end
    end

    // Counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            running_q     <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            de_q          <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            running_q     <= running_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            de_q          <= de_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef SYNCGEN_LOCKLOSS_EN
    logic lock_lost_q, lock_lost_d;

    // Sticky lock-loss flag; a new loss wins over a same-cycle clear.
    always_comb begin
        lock_lost_d = lock_lost_q;
        if (lock_drop) begin
            lock_lost_d = 1'b1;
        end else if (lock_lost_clr) begin
            lock_lost_d = 1'b0;
        end
    end

    // Lock-loss flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_lost_q <= 1'b0;
        end else begin
            lock_lost_q <= lock_lost_d;
        end
    end

    assign lock_lost = lock_lost_q;
`else
    logic unused_lockloss;
    assign unused_lockloss = lock_lost_clr ^ lock_drop;
    assign lock_lost       = 1'b0;
`endif

    assign running     = running_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign de          = de_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_wvga_sync_gen.sv
// tb_wvga_sync_gen: directed bench. Instance a uses the default WVGA timing
// (startup latency, one full line); instance b uses a reduced raster so that
// whole frames, lock loss and mid-frame reset fit in a short run.
module tb_wvga_sync_gen;

    // Reduced timing for instance b: 28 clocks/line, 12 lines/frame.
    localparam int SH_ACT = 16, SH_FP = 4, SH_SY = 3, SH_BP = 5;
    localparam int SV_ACT = 6,  SV_FP = 2, SV_SY = 2, SV_BP = 2;
    localparam int S_SETTLE = 20;

    // Hand-computed expectations.
    localparam int A_LAT      = 1027;  // 2 sync + 1024 settle + 1 output
    localparam int B_LAT      = 23;    // 2 sync + 20 settle + 1 output
    localparam int B_HTOT     = 28;
    localparam int B_FRAME    = 336;   // 28 * 12
    localparam int B_VS_START = 224;   // line 8 * 28
    localparam int B_VS_LEN   = 56;    // 2 lines * 28
    localparam int B_DE_CNT   = 96;    // 16 * 6

    localparam logic [5:0] IDLE = 6'b011000;  // running,hs_n,vs_n,de,ls,fs
    localparam logic [5:0] FIRST = 6'b111111;

`ifdef SYNCGEN_LOCKLOSS_EN
    localparam logic LL_EN = 1'b1;
`else
    localparam logic LL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pll_lock, lock_lost_clr;

    logic       a_running, a_hsync_n, a_vsync_n, a_de, a_line_start, a_frame_start, a_lock_lost;
    logic [9:0] a_pos_x;
    logic [8:0] a_pos_y;
    logic       b_running, b_hsync_n, b_vsync_n, b_de, b_line_start, b_frame_start, b_lock_lost;
    logic [9:0] b_pos_x;
    logic [8:0] b_pos_y;

    logic [5:0] a_flags, b_flags;
    assign a_flags = {a_running, a_hsync_n, a_vsync_n, a_de, a_line_start, a_frame_start};
    assign b_flags = {b_running, b_hsync_n, b_vsync_n, b_de, b_line_start, b_frame_start};

    wvga_sync_gen dut_a (
        .clk           (clk),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .lock_lost_clr (lock_lost_clr),
        .running       (a_running),
        .hsync_n       (a_hsync_n),
        .vsync_n       (a_vsync_n),
        .de            (a_de),
        .pos_x         (a_pos_x),
        .pos_y         (a_pos_y),
        .line_start    (a_line_start),
        .frame_start   (a_frame_start),
        .lock_lost     (a_lock_lost)
    );

    wvga_sync_gen #(
        .H_ACTIVE (SH_ACT), .H_FRONT (SH_FP), .H_SYNC (SH_SY), .H_BACK (SH_BP),
        .V_ACTIVE (SV_ACT), .V_FRONT (SV_FP), .V_SYNC (SV_SY), .V_BACK (SV_BP),
        .LOCK_SETTLE (S_SETTLE)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .lock_lost_clr (lock_lost_clr),
        .running       (b_running),
        .hsync_n       (b_hsync_n),
        .vsync_n       (b_vsync_n),
        .de            (b_de),
        .pos_x         (b_pos_x),
        .pos_y         (b_pos_y),
        .line_start    (b_line_start),
        .frame_start   (b_frame_start),
        .lock_lost     (b_lock_lost)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a_flags"}, 32'(a_flags), 32'(IDLE));
        check({tag, "_b_flags"}, 32'(b_flags), 32'(IDLE));
        check({tag, "_a_pos"}, {13'd0, a_pos_y, a_pos_x}, 32'd0);
        check({tag, "_b_pos"}, {13'd0, b_pos_y, b_pos_x}, 32'd0);
    endtask

    // Counts clocks until each instance shows its first line_start; records
    // whether that first line is also a frame start.
    task automatic measure_start(input string tag);
        int  na = 0, nb = 0;
        logic a_fs = 1'b0, b_fs = 1'b0;
        for (int i = 1; i <= A_LAT + 100; i++) begin
            step();
            if (nb == 0 && b_line_start) begin
                nb   = i;
                b_fs = b_frame_start;
            end
            if (a_line_start) begin
                na   = i;
                a_fs = a_frame_start;
                break;
            end
        end
        check({tag, "_a_latency"}, 32'(na), 32'(A_LAT));
        check({tag, "_b_latency"}, 32'(nb), 32'(B_LAT));
        check({tag, "_a_first_fs"}, 32'(a_fs), 32'd1);
        check({tag, "_b_first_fs"}, 32'(b_fs), 32'd1);
    endtask

    initial begin
        int   de_cnt, hs_cnt, hs_first, next_ls, px_err;
        int   vs_cnt, vs_first, next_fs, max_y, b_de_cnt;
        logic found;

        reset         = 1'b1;
        pll_lock      = 1'b0;
        lock_lost_clr = 1'b0;
        repeat (3) step();
        check_idle("reset");
        check("reset_a_lock_lost", 32'(a_lock_lost), 32'd0);

        // Reset released, lock still low: stays idle.
        reset = 1'b0;
        repeat (6) step();
        check_idle("wait_lock");

        // Lock rises: measure startup on both instances.
        pll_lock = 1'b1;
        measure_start("start");
        check("start_a_flags", 32'(a_flags), 32'(FIRST));
        check("start_a_pos", {13'd0, a_pos_y, a_pos_x}, 32'd0);

        // One full default line on instance a, starting at the current cycle.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; next_ls = -1; px_err = 0;
        for (int t = 0; t <= 1000; t++) begin
            if (t < 1000) begin
                if (a_de) de_cnt++;
                if (!a_hsync_n) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = t;
                end
                if (a_pos_y != 9'd0) px_err++;
                if (t < 800 && a_pos_x != 10'(t)) px_err++;
                if (t >= 800 && a_pos_x != 10'd799) px_err++;
            end
            if (t > 0 && a_line_start && next_ls < 0) next_ls = t;
            if (t < 1000) step();
        end
        check("line_de_cnt", 32'(de_cnt), 32'd800);
        check("line_hs_cnt", 32'(hs_cnt), 32'd48);
        check("line_hs_start", 32'(hs_first), 32'd840);
        check("line_period", 32'(next_ls), 32'd1000);
        check("line_pos_err", 32'(px_err), 32'd0);

        // One full reduced frame on instance b.
        found = 1'b0;
        for (int i = 0; i < 2 * B_FRAME; i++) begin
            if (b_frame_start) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("frame_found", 32'(found), 32'd1);
        vs_cnt = 0; vs_first = -1; next_fs = -1; max_y = 0; b_de_cnt = 0;
        for (int t = 0; t <= B_FRAME; t++) begin
            if (t < B_FRAME) begin
                if (!b_vsync_n) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = t;
                end
                if (b_de) begin
                    b_de_cnt++;
                    if (int'(b_pos_y) > max_y) max_y = int'(b_pos_y);
                end
            end
            if (t > 0 && b_frame_start && next_fs < 0) next_fs = t;
            if (t < B_FRAME) step();
        end
        check("frame_vs_cnt", 32'(vs_cnt), 32'(B_VS_LEN));
        check("frame_vs_start", 32'(vs_first), 32'(B_VS_START));
        check("frame_period", 32'(next_fs), 32'(B_FRAME));
        check("frame_max_y", 32'(max_y), 32'(SV_ACT - 1));
        check("frame_de_cnt", 32'(b_de_cnt), 32'(B_DE_CNT));

        // Lock drop for 5 clocks mid-frame: idle within 3 clocks.
        repeat (B_HTOT * 3 + 5) step();
        check("pre_drop_running", 32'({a_running, b_running}), 32'd3);
        pll_lock = 1'b0;
        repeat (3) step();
        check_idle("drop");
        check("drop_a_lock_lost", 32'(a_lock_lost), 32'(LL_EN));
        check("drop_b_lock_lost", 32'(b_lock_lost), 32'(LL_EN));
        repeat (2) step();
        pll_lock = 1'b1;
        measure_start("relock");
        check("relock_a_pos", {13'd0, a_pos_y, a_pos_x}, 32'd0);
        check("relock_a_lock_lost", 32'(a_lock_lost), 32'(LL_EN));
        check("relock_b_lock_lost", 32'(b_lock_lost), 32'(LL_EN));

        // Clear pulse drops the sticky flag.
        lock_lost_clr = 1'b1;
        step();
        lock_lost_clr = 1'b0;
        check("clr_a_lock_lost", 32'(a_lock_lost), 32'd0);
        check("clr_b_lock_lost", 32'(b_lock_lost), 32'd0);

        // Reset mid-frame on instance b (column 8, row 3), then full restart.
        found = 1'b0;
        for (int i = 0; i < 2 * B_FRAME; i++) begin
            if (b_de && b_pos_x == 10'd8 && b_pos_y == 9'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("midframe_found", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        check_idle("midreset");
        check("midreset_lock_lost", 32'({a_lock_lost, b_lock_lost}), 32'd0);
        reset = 1'b0;
        measure_start("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
